step_sequencer: RTL

- Control-unit stepper: walks each instruction through NUM_STEPS steps, each split into an enable phase and a set phase.
- Emits a one-hot step vector, a binary step number that feeds the control unit's 3-to-8 decoder, and enable/set phase strobes.
- Handles stall, early instruction end (short instructions) and halt at instruction boundaries.
- Counts retired instructions.

---
 rtl/step_sequencer_if.sv | 30 +++
 rtl/step_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/step_sequencer_if.sv
// Bundle of control and status signals between the instruction stepper and the
// control unit. The sequencer connects through the slave modport and the
// control unit through the master modport.
interface step_sequencer_if #(
  parameter int NUM_STEPS = 6,
  parameter int CNT_W     = 16
) ();
  logic                 run;
  logic                 halt_req;
  logic                 stall;
  logic                 end_instr;
  logic [NUM_STEPS-1:0] step_oh;
  logic [2:0]           step_num;
  logic                 en_ph;
  logic                 set_ph;
  logic                 instr_done;
  logic                 busy;
  logic                 halted;
  logic [CNT_W-1:0]     instr_cnt;

  modport slave (
    input  run, halt_req, stall, end_instr,
    output step_oh, step_num, en_ph, set_ph, instr_done, busy, halted, instr_cnt
  );

  modport master (
    output run, halt_req, stall, end_instr,
    input  step_oh, step_num, en_ph, set_ph, instr_done, busy, halted, instr_cnt
  );
endinterface

// File: rtl/step_sequencer.sv
// Instruction stepper: walks each instruction through up to NUM_STEPS steps,
// each made of an enable phase and a set phase, and counts retired instructions.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_IDLE   | no instruction in flight; waits for run (halt_req wins)
// ST_PH_E   | enable phase of step r_s
// ST_PH_S   | set phase of step r_s; retire here on end_instr or last step
// ST_HALTED | stopped at an instruction boundary until rst_n is asserted
module step_sequencer #(
  parameter int NUM_STEPS = 6,
  parameter int CNT_W     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  step_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PH_E   = 2'd1;
  localparam logic [1:0] ST_PH_S   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [2:0]           LAST_STEP = 3'(NUM_STEPS - 1);
  localparam logic [NUM_STEPS-1:0] OH_STEP1  = {{(NUM_STEPS-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [2:0]           r_s;
  logic [NUM_STEPS-1:0] r_step_oh;
  logic [2:0]           r_step_num;
  logic                 r_en_ph;
  logic                 r_in_set;
  logic                 r_instr_done;
  logic                 r_busy;
  logic                 r_halted;
  logic [CNT_W-1:0]     r_instr_cnt;

  logic [1:0]           w_nxt_state;
  logic [2:0]           w_nxt_s;
  logic                 w_retire;
  logic                 w_nxt_active;

  // Next state, next step index and the retire condition.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_s     = r_s;
    w_retire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.halt_req) begin
          w_nxt_state = ST_HALTED;
        end else if (bus.run) begin
          w_nxt_state = ST_PH_E;
          w_nxt_s     = 3'd0;
        end
      end
      ST_PH_E: begin
        if (!bus.stall) w_nxt_state = ST_PH_S;
      end
      ST_PH_S: begin
        if (!bus.stall) begin
          if (bus.end_instr || (r_s == LAST_STEP)) begin
            w_retire = 1'b1;
            w_nxt_s  = 3'd0;
            if (bus.halt_req)  w_nxt_state = ST_HALTED;
            else if (bus.run)  w_nxt_state = ST_PH_E;
            else               w_nxt_state = ST_IDLE;
          end else begin
            w_nxt_s     = r_s + 3'd1;
            w_nxt_state = ST_PH_E;
          end
        end
      end
      default: begin
        w_nxt_state = ST_HALTED;
      end
    endcase
  end

  assign w_nxt_active = (w_nxt_state == ST_PH_E) || (w_nxt_state == ST_PH_S);

  // State, step index and registered decode of the next state onto the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_s          <= 3'd0;
      r_step_oh    <= '0;
      r_step_num   <= 3'd0;
      r_en_ph      <= 1'b0;
      r_in_set     <= 1'b0;
      r_instr_done <= 1'b0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
      r_instr_cnt  <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_s          <= w_nxt_s;
      r_step_oh    <= w_nxt_active ? (OH_STEP1 << w_nxt_s) : '0;
      r_step_num   <= w_nxt_active ? w_nxt_s : 3'd0;
      r_en_ph      <= w_nxt_active;
      r_in_set     <= (w_nxt_state == ST_PH_S);
      r_instr_done <= w_retire;
      r_busy       <= w_nxt_active;
      r_halted     <= (w_nxt_state == ST_HALTED);
      if (w_retire) r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  // The set strobe is the registered set-phase flag qualified by the live
  // stall, so it is low for every stalled cycle and high only in the cycle
  // that actually latches (one cycle per step).
  assign bus.set_ph     = r_in_set & ~bus.stall;
  assign bus.step_oh    = r_step_oh;
  assign bus.step_num   = r_step_num;
  assign bus.en_ph      = r_en_ph;
  assign bus.instr_done = r_instr_done;
  assign bus.busy       = r_busy;
  assign bus.halted     = r_halted;
  assign bus.instr_cnt  = r_instr_cnt;

endmodule
